inv_clark_svm: RTL and testbench
================================

# inv_clark_svm

Parametrised, pipelined inverse Clarke transform for the FOC voltage path. It converts a stationary-frame (alpha, beta) voltage vector into three phase references V1/V2/V3. It can optionally inject min-max zero-sequence to get SVPWM-equivalent references, and saturates every result to the output width. It sits between the inverse Park stage and the PWM comparators, and is triggered by a rising edge on its enable.

## Interface
- W, 16: signed data width of inputs and outputs.
- FRAC, 10: fraction bits of the sqrt(3)/2 coefficient.
- K_SQRT3_2, 886: unsigned coefficient, round(sqrt(3)/2 * (2^FRAC - 1)); FRAC+1 bits wide incl. zero sign bit.

- iClk  in  1  clock, rising edge.
- iRst_n  in  1  reset, asynchronous, active-low.
- iEn  in  1  start; a conversion is requested on a 0->1 transition.
- iMode  in  1  0 = plain inverse Clarke, 1 = min-max zero-sequence injection; latched at accept.
- iValpha  in  W  signed alpha component.
- iVbeta  in  W  signed beta component.
- oV1, oV2, oV3  out  W  signed phase references; registered; hold between conversions.
- oDone  out  1  one-cycle pulse; outputs valid in that cycle.
- oBusy  out  1  conversion in flight.
- oSat  out  1  at least one channel clipped in the current result; updated with oDone.
- oOvr  out  1  one-cycle pulse; a rising edge on iEn was rejected.

## Operation
- Edge detect: register en_q <= iEn, which resets to 0. Rising edge = iEn & !en_q. iEn already high when reset is released counts as an edge on the first clock.
- Accept: a rising edge is accepted when oBusy=0 or oDone=1 in that cycle. Otherwise it is dropped and oOvr pulses. On accept, iValpha, iVbeta and iMode are captured.
- Stage 1:
  - p = (alpha * K_SQRT3_2) >>> FRAC, arithmetic, floor toward -inf.
  - b2 = beta >>> 1.
  - r1 = beta, r2 = p - b2, r3 = -p - b2.
  - r1..r3 are held at W+2 bits; there is no wrap anywhere internally.
- Stage 2: if mode=1, off = (max(r1,r2,r3) + min(r1,r2,r3)) >>> 1 (floor); else off = 0.
- Stage 3:
  - vk = rk - off.
  - Clamp each vk to [-2^(W-1), 2^(W-1)-1] into oVk.
  - oSat = OR of the clip conditions.
  - oDone = 1.
- States: IDLE -> S1 -> S2 -> S3 (done) -> IDLE. From S3 the block goes directly to S1 if an accept occurs in the S3 cycle.
- Reset, including mid-conversion: all outputs and pipeline state go to 0, state goes to IDLE, and no oDone is produced for the aborted conversion.

## Timing
- Reset values: oV1 = oV2 = oV3 = 0, oDone = 0, oBusy = 0, oSat = 0, oOvr = 0, en_q = 0.
- Accept at clock edge t:
  - oBusy = 1 after edges t, t+1 and t+2.
  - After edge t+2, oDone = 1 for exactly one cycle and oV1..3/oSat carry the new result.
  - Latency is 3 clocks from the sampling edge to oDone visible.
- oBusy falls after edge t+3 unless a new accept happened at edge t+3. Maximum throughput is one conversion per 3 clocks.
- oOvr pulses for one cycle, after the edge that sampled the rejected rising edge.
- iEn held high issues exactly one conversion. A new conversion needs iEn low for at least one clock.
- Inputs only need to be stable at the accepting edge.
- oV1..3 and oSat change only together with oDone.

## Test plan
- Plain, alpha=1000, beta=0, mode=0 -> V1=0, V2=865, V3=-865, oSat=0. oDone arrives 3 clocks after the accept edge.
- Injection, alpha=0, beta=1000:
  - mode=0 -> V1=1000, V2=-500, V3=-500.
  - mode=1 -> off=250, giving V1=750, V2=-750, V3=-750.
- Saturation, alpha=-32768, beta=32767, mode=0 -> p=-28352, b2=16383, giving V1=32767, V2=-32768 (clipped from -44735), V3=11969, oSat=1.
- Floor rounding, alpha=-1, beta=-1, mode=0 -> p=-1, b2=-1, giving V1=-1, V2=0, V3=2, oSat=0.
- Handshake:
  - Rising edge at t, second rising edge at t+2 -> oOvr pulse at t+2 and a single oDone.
  - A third rising edge exactly at the oDone cycle -> accepted, and the second oDone follows 3 clocks later.
  - iEn held high for 10 clocks -> one oDone.
- Reset at t+1 of a conversion -> all outputs 0, no oDone. After release with iEn high -> one conversion starts on the first clock.

Source files
------------

// File: rtl/inv_clark_svm.sv
// Pipelined inverse Clarke transform with optional min-max zero-sequence
// injection; converts (alpha, beta) into saturated phase references V1..V3.
module inv_clark_svm #(
  parameter int W         = 16,
  parameter int FRAC      = 10,
  parameter int K_SQRT3_2 = 886
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iEn,
  input  logic                iMode,
  input  logic signed [W-1:0] iValpha,
  input  logic signed [W-1:0] iVbeta,
  output logic signed [W-1:0] oV1,
  output logic signed [W-1:0] oV2,
  output logic signed [W-1:0] oV3,
  output logic                oDone,
  output logic                oBusy,
  output logic                oSat,
  output logic                oOvr
);

  localparam int PW = W + FRAC + 2;
  localparam logic signed [W+2:0] VMAX = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] VMIN = {4'b1111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

  state_t r_state, w_state_nxt;
  logic   r_en_q, r_busy, r_done, r_ovr, r_sat, r_mode;
  logic   w_rise, w_accept;

  logic signed [W+1:0] r_r1_p0, r_r2_p0, r_r3_p0, r_off_p1;
  logic signed [W-1:0] r_v1_p2, r_v2_p2, r_v3_p2;

  logic signed [PW-1:0]  w_a_ext, w_k_ext, w_prod;
  logic signed [W+1:0]   w_p, w_beta_x, w_b2, w_r2, w_r3;
  logic signed [W+1:0]   w_mx, w_mn, w_off;
  logic signed [W+2:0]   w_sum, w_v1, w_v2, w_v3;
  logic                  w_unused;

  function automatic logic signed [W+1:0] max3(input logic signed [W+1:0] a, b, c);
    logic signed [W+1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic signed [W+1:0] min3(input logic signed [W+1:0] a, b, c);
    logic signed [W+1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [W+2:0] v);
    if (v > VMAX)      return VMAX[W-1:0];
    else if (v < VMIN) return VMIN[W-1:0];
    else               return v[W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [W+2:0] v);
    return (v > VMAX) || (v < VMIN);
  endfunction

  // Edge detect and accept: a new start may overlap the done cycle.
  assign w_rise   = iEn & ~r_en_q;
  assign w_accept = w_rise & (~r_busy | r_done);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = S1;
      S1:      w_state_nxt = S2;
      S2:      w_state_nxt = S3;
      S3:      w_state_nxt = w_accept ? S1 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage 1 (at accept): p = floor(alpha*K / 2^FRAC), r = beta, p-b/2, -p-b/2
  assign w_a_ext  = {{(FRAC+2){iValpha[W-1]}}, iValpha};
  assign w_k_ext  = PW'(K_SQRT3_2);
  assign w_prod   = w_a_ext * w_k_ext;
  assign w_p      = w_prod[FRAC +: W+2];
  assign w_beta_x = {{2{iVbeta[W-1]}}, iVbeta};
  assign w_b2     = w_beta_x >>> 1;
  assign w_r2     = w_p - w_b2;
  assign w_r3     = -w_p - w_b2;

  // Stage 2: min-max zero-sequence offset, floor-halved
  assign w_mx  = max3(r_r1_p0, r_r2_p0, r_r3_p0);
  assign w_mn  = min3(r_r1_p0, r_r2_p0, r_r3_p0);
  assign w_sum = {w_mx[W+1], w_mx} + {w_mn[W+1], w_mn};
  assign w_off = r_mode ? w_sum[W+2:1] : '0;

  // Stage 3: subtract offset, then clamp to the output range
  assign w_v1 = {r_r1_p0[W+1], r_r1_p0} - {r_off_p1[W+1], r_off_p1};
  assign w_v2 = {r_r2_p0[W+1], r_r2_p0} - {r_off_p1[W+1], r_off_p1};
  assign w_v3 = {r_r3_p0[W+1], r_r3_p0} - {r_off_p1[W+1], r_off_p1};

  assign w_unused = ^{w_prod[FRAC-1:0], w_sum[0]};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_en_q  <= 1'b0;
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_en_q  <= iEn;
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == S3);
      r_ovr   <= w_rise & ~w_accept;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_mode   <= 1'b0;
      r_r1_p0  <= '0;
      r_r2_p0  <= '0;
      r_r3_p0  <= '0;
      r_off_p1 <= '0;
      r_v1_p2  <= '0;
      r_v2_p2  <= '0;
      r_v3_p2  <= '0;
      r_sat    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode  <= iMode;
        r_r1_p0 <= w_beta_x;
        r_r2_p0 <= w_r2;
        r_r3_p0 <= w_r3;
      end
      if (r_state == S1) r_off_p1 <= w_off;
      if (r_state == S2) begin
        r_v1_p2 <= sat(w_v1);
        r_v2_p2 <= sat(w_v2);
        r_v3_p2 <= sat(w_v3);
        r_sat   <= clipped(w_v1) | clipped(w_v2) | clipped(w_v3);
      end
    end
  end

  assign oV1   = r_v1_p2;
  assign oV2   = r_v2_p2;
  assign oV3   = r_v3_p2;
  assign oSat  = r_sat;
  assign oDone = r_done;
  assign oBusy = r_busy;
  assign oOvr  = r_ovr;

endmodule

// File: tb/tb_inv_clark_svm.sv
// Self-checking bench for inv_clark_svm: directed plan cases, handshake
// scenarios, reset abort and randomized conversions against a reference model.
module tb_inv_clark_svm;
  localparam int W = 16;

  logic iClk = 1'b0, iRst_n = 1'b0, iEn = 1'b0, iMode = 1'b0;
  logic signed [W-1:0] iValpha = '0, iVbeta = '0;
  logic signed [W-1:0] oV1, oV2, oV3;
  logic oDone, oBusy, oSat, oOvr;

  int ncmp = 0, nfail = 0, ndone = 0;

  always #5 iClk = ~iClk;

  inv_clark_svm #(.W(W), .FRAC(10), .K_SQRT3_2(886)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iMode(iMode),
    .iValpha(iValpha), .iVbeta(iVbeta),
    .oV1(oV1), .oV2(oV2), .oV3(oV3),
    .oDone(oDone), .oBusy(oBusy), .oSat(oSat), .oOvr(oOvr)
  );

  always @(negedge iClk) if (oDone) ndone++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input longint v, output bit c);
    c = 1'b0;
    if (v > 32767)  begin c = 1'b1; return 32767;  end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return int'(v);
  endfunction

  // Reference: plain integer arithmetic straight from the transform's definition.
  task automatic model(input int a, input int b, input bit m,
                       output int v1, output int v2, output int v3, output bit s);
    longint p, b2, r1, r2, r3, mx, mn, off;
    bit c1, c2, c3;
    p  = (longint'(a) * 886) >>> 10;
    b2 = longint'(b) >>> 1;
    r1 = b;
    r2 = p - b2;
    r3 = -p - b2;
    mx = r1; if (r2 > mx) mx = r2; if (r3 > mx) mx = r3;
    mn = r1; if (r2 < mn) mn = r2; if (r3 < mn) mn = r3;
    off = m ? ((mx + mn) >>> 1) : 0;
    v1 = clamp(r1 - off, c1);
    v2 = clamp(r2 - off, c2);
    v3 = clamp(r3 - off, c3);
    s  = c1 | c2 | c3;
  endtask

  task automatic check_result(input string tag, input int a, input int b, input bit m);
    int e1, e2, e3; bit es;
    model(a, b, m, e1, e2, e3, es);
    check({tag, "_v1"}, oV1, e1);
    check({tag, "_v2"}, oV2, e2);
    check({tag, "_v3"}, oV3, e3);
    check({tag, "_sat"}, oSat, es);
  endtask

  task automatic conv(input string tag, input int a, input int b, input bit m);
    logic [W-1:0] ta, tb;
    ta = a[W-1:0];
    tb = b[W-1:0];
    @(negedge iClk); iEn = 1'b0;
    @(negedge iClk); iValpha = ta; iVbeta = tb; iMode = m; iEn = 1'b1;
    @(negedge iClk);
    check({tag, "_busy_t"}, oBusy, 1);
    check({tag, "_done_t"}, oDone, 0);
    iEn = 1'b0; iValpha = W'($urandom); iVbeta = W'($urandom); iMode = ~m;
    @(negedge iClk);
    check({tag, "_done_t1"}, oDone, 0);
    @(negedge iClk);
    check({tag, "_done_t2"}, oDone, 1);
    check({tag, "_ovr"}, oOvr, 0);
    check_result(tag, a, b, m);
    @(negedge iClk);
    check({tag, "_done_t3"}, oDone, 0);
    check({tag, "_busy_t3"}, oBusy, 0);
    check_result({tag, "_hold"}, a, b, m);
  endtask

  initial begin
    int base, a, b, e1, e2, e3;
    bit m, es;

    // Reset state
    #2;
    check("rst_v1", oV1, 0);  check("rst_v2", oV2, 0);  check("rst_v3", oV3, 0);
    check("rst_done", oDone, 0); check("rst_busy", oBusy, 0);
    check("rst_sat", oSat, 0);   check("rst_ovr", oOvr, 0);
    @(negedge iClk); @(negedge iClk); iRst_n = 1'b1;

    // Directed plan cases
    conv("plain", 1000, 0, 0);
    check("plan_plain_v2", oV2, 865);
    check("plan_plain_v3", oV3, -865);
    conv("inj_m0", 0, 1000, 0);
    check("plan_inj0_v2", oV2, -500);
    conv("inj_m1", 0, 1000, 1);
    check("plan_inj1_v1", oV1, 750);
    check("plan_inj1_v3", oV3, -750);
    conv("satur", -32768, 32767, 0);
    check("plan_sat_v2", oV2, -32768);
    check("plan_sat_v3", oV3, 11969);
    check("plan_sat_flag", oSat, 1);
    conv("floor", -1, -1, 0);
    check("plan_floor_v2", oV2, 0);
    check("plan_floor_v3", oV3, 2);

    // Second rising edge at t+2 is rejected
    @(negedge iClk); iEn = 1'b0; iValpha = 100; iVbeta = 200; iMode = 1'b0;
    base = ndone;
    @(negedge iClk); iEn = 1'b1;
    @(negedge iClk); iEn = 1'b0;
    @(negedge iClk); iEn = 1'b1; iValpha = 5000; iVbeta = -5000;
    @(negedge iClk);
    check("ovr_pulse", oOvr, 1);
    check("ovr_done", oDone, 1);
    check_result("ovr_res", 100, 200, 0);
    @(negedge iClk);
    check("ovr_clear", oOvr, 0);
    iEn = 1'b0;
    repeat (4) @(negedge iClk);
    check("ovr_single_done", ndone - base, 1);

    // Rising edge exactly in the done cycle is accepted
    @(negedge iClk); iValpha = 300; iVbeta = -400; iMode = 1'b1; iEn = 1'b1;
    @(negedge iClk); iEn = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    check("b2b_done1", oDone, 1);
    check_result("b2b_res1", 300, -400, 1);
    iValpha = -2000; iVbeta = 1500; iMode = 1'b1; iEn = 1'b1;
    @(negedge iClk);
    check("b2b_gap_done", oDone, 0);
    check("b2b_gap_busy", oBusy, 1);
    check("b2b_gap_ovr", oOvr, 0);
    iEn = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    check("b2b_done2", oDone, 1);
    check_result("b2b_res2", -2000, 1500, 1);

    // iEn held high for 10 clocks yields one conversion
    @(negedge iClk); iEn = 1'b0;
    base = ndone;
    @(negedge iClk); iEn = 1'b1; iValpha = 1234; iVbeta = -321; iMode = 1'b0;
    repeat (10) @(negedge iClk);
    iEn = 1'b0;
    repeat (4) @(negedge iClk);
    check("held_one_done", ndone - base, 1);
    check_result("held_res", 1234, -321, 0);

    // Reset during a conversion aborts it; iEn high at release starts a new one
    @(negedge iClk); iValpha = 777; iVbeta = 888; iMode = 1'b1; iEn = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    base = ndone;
    check("arst_v1", oV1, 0); check("arst_v2", oV2, 0); check("arst_v3", oV3, 0);
    check("arst_busy", oBusy, 0); check("arst_done", oDone, 0); check("arst_sat", oSat, 0);
    repeat (3) @(negedge iClk);
    check("arst_no_done", ndone - base, 0);
    iRst_n = 1'b1;
    @(negedge iClk);
    check("rel_busy", oBusy, 1);
    iEn = 1'b0;
    @(negedge iClk);
    check("rel_done_t1", oDone, 0);
    @(negedge iClk);
    check("rel_done_t2", oDone, 1);
    check_result("rel_res", 777, 888, 1);

    // Randomized conversions, biased toward the extremes
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = -32768;
        1:       a = 32767;
        default: a = int'($signed(W'($urandom)));
      endcase
      case ($urandom_range(0, 3))
        0:       b = -32768;
        1:       b = 32767;
        default: b = int'($signed(W'($urandom)));
      endcase
      m = 1'($urandom);
      conv("rand", a, b, m);
    end
    model(0, 0, 0, e1, e2, e3, es);
    conv("zero", 0, 0, 0);
    check("zero_v1", oV1, e1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
